// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_ctrl_pkg                                                             |
// | Opcodes, access sizes, FSM states and decode helpers for mem_ctrl.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    localparam logic [2:0] SIZE_B = 3'd1;
    localparam logic [2:0] SIZE_H = 3'd2;
    localparam logic [2:0] SIZE_W = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_LSB = 1'b1
    } grant_t;

    function automatic logic [2:0] op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SIZE_B;
            OP_LH, OP_LHU, OP_SH: op_size = SIZE_H;
            default:              op_size = SIZE_W;
        endcase
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        op_signed = (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_ctrl                                                                 |
// | Byte-wide RAM/IO bus owner: round-robin IF/LSB arbitration, byte        |
// | sequencing, load extension, UART-full store stall and flush abort.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_ls,
    input  logic [5:0]  lsb_opcode,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata
);

    state_t      r_state;
    state_t      w_next_state;
    grant_t      r_last_grant;
    grant_t      r_cur;
    grant_t      w_grant;
    logic        w_grant_valid;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [31:0] r_if_data;
    logic [31:0] r_lsb_rdata;
    logic [2:0]  r_size;
    logic [2:0]  r_idx;
    logic        r_signed;
    logic        r_flushed;
    logic        r_if_done;
    logic        r_lsb_done;

    logic [31:0] w_byte_addr;
    logic [31:0] w_assembled;
    logic [7:0]  w_wbyte;
    logic        w_io_stall;
    logic        w_wr;

    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input logic [2:0]  size,
                                           input logic        sgn);
        logic [31:0] v;
        case (size)
            SIZE_B:  v = {{24{sgn & raw[7]}}, raw[7:0]};
            SIZE_H:  v = {{16{sgn & raw[15]}}, raw[15:0]};
            default: v = raw;
        endcase
        return v;
    endfunction

    assign w_byte_addr = r_addr + {29'd0, r_idx};
    assign w_io_stall  = (r_state == ST_WRITE) && (w_byte_addr >= IO_BASE) && io_buffer_full;

    // mem_din carries the byte addressed one cycle earlier, i.e. byte r_idx-1
    always_comb begin
        w_assembled = r_buf;
        case (r_idx)
            3'd1:    w_assembled[7:0]   = mem_din;
            3'd2:    w_assembled[15:8]  = mem_din;
            3'd3:    w_assembled[23:16] = mem_din;
            3'd4:    w_assembled[31:24] = mem_din;
            default: ;
        endcase
    end

    always_comb begin
        case (r_idx[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (rdy) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_grant       = r_last_grant;
        w_wr          = 1'b0;
        mem_a         = 32'd0;
        mem_dout      = 8'd0;
        case (r_state)
            ST_IDLE: begin
                if (if_req && lsb_req) begin
                    w_grant_valid = 1'b1;
                    w_grant       = (r_last_grant == GNT_IF) ? GNT_LSB : GNT_IF;
                end else if (lsb_req) begin
                    w_grant_valid = 1'b1;
                    w_grant       = GNT_LSB;
                end else if (if_req) begin
                    w_grant_valid = 1'b1;
                    w_grant       = GNT_IF;
                end
                if (w_grant_valid) begin
                    w_next_state = (w_grant == GNT_LSB && !lsb_ls) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (r_idx < r_size) begin
                    mem_a = w_byte_addr;
                end
                if (flush) begin
                    w_next_state = ST_IDLE;
                end else if (r_idx == r_size) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (!w_io_stall) begin
                    w_wr     = 1'b1;
                    mem_a    = w_byte_addr;
                    mem_dout = w_wbyte;
                    if (r_idx == r_size - 3'd1) begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign mem_wr = w_wr & rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GNT_IF;
            r_cur        <= GNT_IF;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_buf        <= 32'd0;
            r_size       <= 3'd0;
            r_idx        <= 3'd0;
            r_signed     <= 1'b0;
            r_flushed    <= 1'b0;
            r_if_done    <= 1'b0;
            r_lsb_done   <= 1'b0;
            r_if_data    <= 32'd0;
            r_lsb_rdata  <= 32'd0;
        end else if (rdy) begin
            r_if_done  <= 1'b0;
            r_lsb_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_cur     <= w_grant;
                        r_idx     <= 3'd0;
                        r_buf     <= 32'd0;
                        r_flushed <= 1'b0;
                        if (w_grant == GNT_IF) begin
                            r_addr   <= if_addr;
                            r_size   <= SIZE_W;
                            r_signed <= 1'b0;
                        end else begin
                            r_addr   <= lsb_addr;
                            r_size   <= op_size(lsb_opcode);
                            r_signed <= op_signed(lsb_opcode);
                            r_wdata  <= lsb_wdata;
                        end
                    end
                end
                ST_READ: begin
                    if (!flush) begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx != 3'd0) begin
                            r_buf <= w_assembled;
                        end
                        if (r_idx == r_size) begin
                            if (r_cur == GNT_IF) begin
                                r_if_done <= 1'b1;
                                r_if_data <= w_assembled;
                            end else begin
                                r_lsb_done  <= 1'b1;
                                r_lsb_rdata <= extend(w_assembled, r_size, r_signed);
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    // a committed store finishes its bytes but reports nothing once flushed
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (!w_io_stall) begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == r_size - 3'd1 && !(r_flushed || flush)) begin
                            r_lsb_done <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_last_grant <= r_cur;
                end
                default: ;
            endcase
        end
    end

    assign if_done   = r_if_done;
    assign if_data   = r_if_data;
    assign lsb_done  = r_lsb_done;
    assign lsb_rdata = r_lsb_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_ctrl                                                              |
// | Randomised self-checking bench for mem_ctrl with a byte-RAM model.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam logic [31:0] C_IO_BASE = 32'h0003_0000;
    localparam int          C_MEMW    = 4096 + 256;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        lsb_req, lsb_ls, lsb_done;
    logic [5:0]  lsb_opcode;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;

    int   n_checks = 0;
    int   n_errors = 0;
    logic m_last_lsb;
    logic [5:0] op_tab [0:7];

    always #5 clk = ~clk;

    mem_ctrl #(.IO_BASE(C_IO_BASE)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_ls(lsb_ls), .lsb_opcode(lsb_opcode),
        .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_done(lsb_done), .lsb_rdata(lsb_rdata)
    );

    // RAM: low 4 KiB plus a 256-byte window at the I/O base
    logic [7:0] wram   [0:C_MEMW-1];
    bit         wvalid [0:C_MEMW-1];

    function automatic int midx(input logic [31:0] a);
        if (a >= C_IO_BASE) return 4096 + int'(a[7:0]);
        return int'(a[11:0]);
    endfunction

    function automatic logic [7:0] base_byte(input logic [31:0] a);
        case (a)
            32'h80:  return 8'h80;
            32'h90:  return 8'h01;
            32'h91:  return 8'h80;
            32'h100: return 8'h78;
            32'h101: return 8'h56;
            32'h102: return 8'h34;
            32'h103: return 8'h12;
            default: return a[7:0] ^ {a[3:0], a[11:8]} ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        int i = midx(a);
        return wvalid[i] ? wram[i] : base_byte(a);
    endfunction

    always @(posedge clk) begin
        if (mem_wr === 1'b1) begin
            wram[midx(mem_a)]   <= mem_dout;
            wvalid[midx(mem_a)] <= 1'b1;
        end
        mem_din <= rd_byte(mem_a);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int op_bytes(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_value(input logic [5:0] op, input logic [31:0] addr);
        longint raw = 0;
        for (int i = 0; i < op_bytes(op); i++)
            raw += longint'(rd_byte(addr + 32'(i))) << (8 * i);
        if (op == OP_LB && raw >= 128)   raw -= 256;
        if (op == OP_LH && raw >= 32768) raw -= 65536;
        return raw[31:0];
    endfunction

    task automatic lsb_txn(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int stall);
        int          n        = op_bytes(op);
        logic        is_store = (op == OP_SB || op == OP_SH || op == OP_SW);
        logic        is_io    = (addr >= C_IO_BASE);
        int          st       = (is_store && is_io) ? stall : 0;
        int          exp_done = is_store ? st + n + 1 : n + 2;
        logic [31:0] exp_rd   = load_value(op, addr);
        logic [7:0]  after_b  = rd_byte(addr + 32'(n));
        lsb_req = 1'b1; lsb_ls = !is_store; lsb_opcode = op; lsb_addr = addr; lsb_wdata = wd;
        for (int k = 1; k <= exp_done + 1; k++) begin
            @(posedge clk); #1;
            if (k == exp_done + 1) lsb_req = 1'b0;
            if (is_store && is_io) io_buffer_full = (k <= st);
            else                   io_buffer_full = 1'($urandom_range(0, 1));
            #1;
            if (!is_store) begin
                if (k <= n) begin
                    check_eq("ld_addr", mem_a, addr + 32'(k - 1));
                    check_eq("ld_wr", 32'(mem_wr), 32'd0);
                end
            end else if (k <= st) begin
                check_eq("st_stall_wr", 32'(mem_wr), 32'd0);
                check_eq("st_stall_a", mem_a, 32'd0);
            end else if (k <= st + n) begin
                check_eq("st_wr", 32'(mem_wr), 32'd1);
                check_eq("st_addr", mem_a, addr + 32'(k - st - 1));
                check_eq("st_dout", 32'(mem_dout), (wd >> (8 * (k - st - 1))) & 32'hFF);
            end
            check_eq("lsb_done", 32'(lsb_done), 32'(k == exp_done));
            check_eq("if_done_quiet", 32'(if_done), 32'd0);
            if (k == exp_done && !is_store) check_eq("lsb_rdata", lsb_rdata, exp_rd);
        end
        io_buffer_full = 1'b0;
        if (is_store) begin
            for (int i = 0; i < n; i++)
                check_eq("st_mem", 32'(rd_byte(addr + 32'(i))), (wd >> (8 * i)) & 32'hFF);
            check_eq("st_mem_next", 32'(rd_byte(addr + 32'(n))), 32'(after_b));
        end
        m_last_lsb = 1'b1;
    endtask

    task automatic if_txn(input logic [31:0] addr);
        logic [31:0] exp = load_value(OP_LW, addr);
        if_req = 1'b1; if_addr = addr;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 7) if_req = 1'b0;
            io_buffer_full = 1'($urandom_range(0, 1));
            #1;
            if (k <= 4) begin
                check_eq("if_addr", mem_a, addr + 32'(k - 1));
                check_eq("if_wr", 32'(mem_wr), 32'd0);
            end
            check_eq("if_done", 32'(if_done), 32'(k == 6));
            check_eq("lsb_done_quiet", 32'(lsb_done), 32'd0);
            if (k == 6) check_eq("if_data", if_data, exp);
        end
        io_buffer_full = 1'b0;
        m_last_lsb = 1'b0;
    endtask

    task automatic both_txn(input logic [5:0] op, input logic [31:0] laddr, input logic [31:0] iaddr);
        logic        exp_first_lsb = !m_last_lsb;
        logic [31:0] exp_l = load_value(op, laddr);
        logic [31:0] exp_i = load_value(OP_LW, iaddr);
        logic got_l = 0, got_i = 0, drop_l = 0, drop_i = 0, first_lsb = 0;
        lsb_req = 1'b1; lsb_ls = 1'b1; lsb_opcode = op; lsb_addr = laddr;
        if_req = 1'b1; if_addr = iaddr;
        for (int k = 1; k <= 40 && !(got_l && got_i && !if_req && !lsb_req); k++) begin
            @(posedge clk); #1;
            if (drop_l) begin lsb_req = 1'b0; drop_l = 0; end
            if (drop_i) begin if_req = 1'b0; drop_i = 0; end
            #1;
            if (lsb_done) begin
                if (!got_l && !got_i) first_lsb = 1;
                got_l = 1; drop_l = 1;
                check_eq("arb_lsb_data", lsb_rdata, exp_l);
            end
            if (if_done) begin
                got_i = 1; drop_i = 1;
                check_eq("arb_if_data", if_data, exp_i);
            end
        end
        lsb_req = 1'b0; if_req = 1'b0;
        check_eq("arb_both_done", 32'(got_l && got_i), 32'd1);
        check_eq("arb_first_lsb", 32'(first_lsb), 32'(exp_first_lsb));
        m_last_lsb = !exp_first_lsb;
    endtask

    task automatic flush_if(input logic [31:0] addr);
        if_req = 1'b1; if_addr = addr;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin flush = 1'b1; if_req = 1'b0; end
            if (k == 3) flush = 1'b0;
            #1;
            if (k == 2) check_eq("fl_if_addr", mem_a, addr + 32'd1);
            if (k == 3) check_eq("fl_if_a0", mem_a, 32'd0);
            check_eq("fl_if_nodone", 32'(if_done), 32'd0);
        end
    endtask

    task automatic flush_sw(input logic [31:0] addr, input logic [31:0] wd);
        lsb_req = 1'b1; lsb_ls = 1'b0; lsb_opcode = OP_SW; lsb_addr = addr; lsb_wdata = wd;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin flush = 1'b1; lsb_req = 1'b0; end
            if (k == 3) flush = 1'b0;
            #1;
            check_eq("fl_sw_nodone", 32'(lsb_done), 32'd0);
        end
        for (int i = 0; i < 4; i++)
            check_eq("fl_sw_mem", 32'(rd_byte(addr + 32'(i))), (wd >> (8 * i)) & 32'hFF);
        m_last_lsb = 1'b1;
    endtask

    task automatic rdy_sw(input logic [31:0] addr, input logic [31:0] wd);
        int done_k = 0;
        lsb_req = 1'b1; lsb_ls = 1'b0; lsb_opcode = OP_SW; lsb_addr = addr; lsb_wdata = wd;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            rdy = !(k == 2 || k == 3);
            if (k == 8) lsb_req = 1'b0;
            #1;
            if (!rdy) check_eq("rdy_low_wr", 32'(mem_wr), 32'd0);
            if (lsb_done && done_k == 0) done_k = k;
        end
        check_eq("rdy_done_cycle", 32'(done_k), 32'd7);
        for (int i = 0; i < 4; i++)
            check_eq("rdy_mem", 32'(rd_byte(addr + 32'(i))), (wd >> (8 * i)) & 32'hFF);
        m_last_lsb = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        int          kind;
        op_tab = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        lsb_req = 1'b0; lsb_ls = 1'b0; lsb_opcode = 6'd0; lsb_addr = 32'd0; lsb_wdata = 32'd0;
        m_last_lsb = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; #1;

        check_eq("rst_mem_a", mem_a, 32'd0);
        check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
        check_eq("rst_if_done", 32'(if_done), 32'd0);
        check_eq("rst_lsb_done", 32'(lsb_done), 32'd0);
        check_eq("rst_if_data", if_data, 32'd0);
        check_eq("rst_lsb_rdata", lsb_rdata, 32'd0);

        both_txn(OP_LW, 32'h100, 32'h200);
        lsb_txn(OP_LW,  32'h100, 32'd0, 0);
        lsb_txn(OP_LB,  32'h80,  32'd0, 0);
        lsb_txn(OP_LBU, 32'h80,  32'd0, 0);
        lsb_txn(OP_LH,  32'h90,  32'd0, 0);
        lsb_txn(OP_SH,  32'h200, 32'hABCD1234, 0);
        both_txn(OP_LHU, 32'h300, 32'h400);
        flush_if(32'h500);
        flush_sw(32'h600, 32'hCAFEF00D);
        if_txn(32'h700);
        rdy_sw(32'h680, 32'h89ABCDEF);
        lsb_txn(OP_SB,  C_IO_BASE, 32'h0000005A, 3);
        lsb_txn(OP_LB,  C_IO_BASE + 32'h10, 32'd0, 0);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                if_txn(32'($urandom_range(0, 4080)));
            end else if (kind == 2) begin
                both_txn(op_tab[$urandom_range(0, 4)], 32'($urandom_range(0, 4080)),
                         32'($urandom_range(0, 4080)));
            end else begin
                op = op_tab[$urandom_range(0, 7)];
                if ($urandom_range(0, 2) == 0) a = C_IO_BASE + 32'($urandom_range(0, 240));
                else                           a = 32'($urandom_range(0, 4080));
                lsb_txn(op, a, $urandom, $urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
